// File: rtl/sm_xbee_pkg.sv
// Shared encodings for the Xbee link: ASCII constants, input code maps,
// per-type message lengths and the character table both link ends agree on.
package sm_xbee_pkg;

  localparam int CPB = 434;

  typedef enum logic [1:0] {MSG_SI = 2'd0, MSG_SPIM = 2'd1, MSG_SDM = 2'd2, MSG_RSVD = 2'd3} msg_type_e;
  typedef enum logic [1:0] {COL_N = 2'd0, COL_R = 2'd1, COL_B = 2'd2, COL_G = 2'd3} color_e;
  typedef enum logic [1:0] {FLD_MT = 2'd0, FLD_PP = 2'd1, FLD_VG = 2'd2, FLD_NG = 2'd3} field_e;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_e;

  localparam logic [7:0] ASC_DASH = 8'h2D;
  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_B    = 8'h42;
  localparam logic [7:0] ASC_D    = 8'h44;
  localparam logic [7:0] ASC_G    = 8'h47;
  localparam logic [7:0] ASC_I    = 8'h49;
  localparam logic [7:0] ASC_M    = 8'h4D;
  localparam logic [7:0] ASC_N    = 8'h4E;
  localparam logic [7:0] ASC_P    = 8'h50;
  localparam logic [7:0] ASC_R    = 8'h52;
  localparam logic [7:0] ASC_S    = 8'h53;
  localparam logic [7:0] ASC_T    = 8'h54;
  localparam logic [7:0] ASC_V    = 8'h56;
  localparam logic [7:0] ASC_LC_I = 8'h69;

  localparam logic [3:0] LEN_SI   = 4'd6;
  localparam logic [3:0] LEN_SPIM = 4'd11;
  localparam logic [3:0] LEN_SDM  = 4'd8;

  function automatic logic [3:0] msg_len(input logic [1:0] t);
    case (msg_type_e'(t))
      MSG_SI:   return LEN_SI;
      MSG_SPIM: return LEN_SPIM;
      MSG_SDM:  return LEN_SDM;
      default:  return 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] color_char(input logic [1:0] c);
    case (color_e'(c))
      COL_N:   return ASC_N;
      COL_R:   return ASC_R;
      COL_B:   return ASC_B;
      default: return ASC_G;
    endcase
  endfunction

  function automatic logic [7:0] field_char(input logic [1:0] f, input logic second);
    case (field_e'(f))
      FLD_MT:  return second ? ASC_T : ASC_M;
      FLD_PP:  return ASC_P;
      FLD_VG:  return second ? ASC_G : ASC_V;
      default: return second ? ASC_G : ASC_N;
    endcase
  endfunction

  function automatic logic [7:0] msg_char(input logic [1:0] t, input logic [1:0] n,
                                          input logic [1:0] c, input logic [1:0] f,
                                          input logic [3:0] idx);
    logic [7:0] ch;
    ch = ASC_HASH;
    case (msg_type_e'(t))
      MSG_SI: begin
        case (idx)
          4'd0:    ch = ASC_S;
          4'd1:    ch = ASC_I;
          4'd3:    ch = ASC_0 + {6'd0, n};
          4'd2, 4'd4: ch = ASC_DASH;
          default: ch = ASC_HASH;
        endcase
      end
      MSG_SPIM: begin
        case (idx)
          4'd0:    ch = ASC_S;
          4'd1:    ch = ASC_P;
          4'd2:    ch = ASC_LC_I;
          4'd3:    ch = ASC_M;
          4'd5:    ch = color_char(c);
          4'd7:    ch = field_char(f, 1'b0);
          4'd8:    ch = field_char(f, 1'b1);
          4'd4, 4'd6, 4'd9: ch = ASC_DASH;
          default: ch = ASC_HASH;
        endcase
      end
      MSG_SDM: begin
        case (idx)
          4'd0:    ch = ASC_S;
          4'd1:    ch = ASC_D;
          4'd2:    ch = ASC_M;
          4'd4:    ch = field_char(f, 1'b0);
          4'd5:    ch = field_char(f, 1'b1);
          4'd3, 4'd6: ch = ASC_DASH;
          default: ch = ASC_HASH;
        endcase
      end
      default: ch = ASC_HASH;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/sm_xbee_msg_transmitter_if.sv
// Request/status bundle between the task FSM (master) and the transmitter (slave).
interface sm_xbee_msg_transmitter_if;
  logic       start;
  logic [1:0] msg_type;
  logic [1:0] node_si;
  logic [1:0] color;
  logic [1:0] field;
  logic       tx;
  logic       tx_busy;
  logic       tx_complete;

  modport master (output start, msg_type, node_si, color, field,
                  input  tx, tx_busy, tx_complete);
  modport slave  (input  start, msg_type, node_si, color, field,
                  output tx, tx_busy, tx_complete);
endinterface

// File: rtl/sm_uart_tx_byte.sv
// 8N1 byte serialiser; done_o marks the last cycle of the stop bit so the
// caller can chain the next byte with no idle gap.
module sm_uart_tx_byte
  import sm_xbee_pkg::*;
#(
  parameter int CPB = sm_xbee_pkg::CPB
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

  tx_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        bit_end_s;

  assign bit_end_s = (cnt_q == CNT_MAX);
  assign done_o    = (state_q == TX_STOP) && bit_end_s;
  assign tx_o      = tx_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          cnt_q <= '0;
          bit_q <= 3'd0;
          if (load_i) begin
            state_q <= TX_START;
            shift_q <= data_i;
            tx_q    <= 1'b0;
          end else begin
            tx_q <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_end_s) begin
            cnt_q   <= '0;
            state_q <= TX_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          if (bit_end_s) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
              bit_q   <= 3'd0;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          if (bit_end_s) begin
            cnt_q <= '0;
            // Chained byte: start bit follows the stop bit directly.
            if (load_i) begin
              state_q <= TX_START;
              shift_q <= data_i;
              tx_q    <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= TX_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/sm_xbee_msg_transmitter.sv
// Xbee status-message transmitter: latches a request, walks the message
// characters and feeds them back-to-back into the byte serialiser.
module sm_xbee_msg_transmitter
  import sm_xbee_pkg::*;
#(
  parameter int CPB = sm_xbee_pkg::CPB
) (
  input  logic clk_50m,
  input  logic rst_n,
  sm_xbee_msg_transmitter_if.slave bus
);
  logic [1:0] type_q, node_q, color_q, field_q;
  logic [3:0] idx_q, idx_d;
  logic       busy_q, complete_q;
  logic       accept_s, more_s, byte_done_s, load_s, tx_s;
  logic [7:0] byte_s;

  // A reserved type or SI without a node number is dropped silently.
  assign accept_s = bus.start && !busy_q && (bus.msg_type != 2'd3) &&
                    !((bus.msg_type == 2'd0) && (bus.node_si == 2'd0));
  assign idx_d    = idx_q + 4'd1;
  assign more_s   = (idx_d != msg_len(type_q));
  assign load_s   = accept_s || (byte_done_s && more_s);
  assign byte_s   = accept_s ? msg_char(bus.msg_type, bus.node_si, bus.color, bus.field, 4'd0)
                             : msg_char(type_q, node_q, color_q, field_q, idx_d);

  sm_uart_tx_byte #(.CPB(CPB)) u_byte (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .load_i  (load_s),
    .data_i  (byte_s),
    .tx_o    (tx_s),
    .done_o  (byte_done_s)
  );

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      type_q     <= 2'd0;
      node_q     <= 2'd0;
      color_q    <= 2'd0;
      field_q    <= 2'd0;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      if (accept_s) begin
        type_q  <= bus.msg_type;
        node_q  <= bus.node_si;
        color_q <= bus.color;
        field_q <= bus.field;
        idx_q   <= 4'd0;
        busy_q  <= 1'b1;
      end else if (byte_done_s) begin
        if (more_s) begin
          idx_q <= idx_d;
        end else begin
          idx_q      <= 4'd0;
          busy_q     <= 1'b0;
          complete_q <= 1'b1;
        end
      end else begin
        idx_q <= idx_q;
      end
    end
  end

  assign bus.tx          = tx_s;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_complete = complete_q;
endmodule
